// File: rtl/nes_pad_pkg.sv
// nes_pad_pkg: shared FSM state type and scan timing helper
// for the NES/SNES controller scanner.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  // Cycles from the first LATCH cycle to the DONE cycle, inclusive.
  function automatic int scan_len(input int h, input int nbits);
    return 2 * h + nbits * h + (nbits - 1) * h + 1;
  endfunction

endpackage

// File: rtl/nes_pad_tick.sv
// nes_pad_tick: free-running auto-poll divider, one-cycle tick
// every POLL_CYC cycles; POLL_CYC = 0 never ticks.
module nes_pad_tick #(
  parameter int POLL_CYC = 450000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  if (POLL_CYC > 0) begin : g_on
    localparam int W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(POLL_CYC - 1);

    logic [W-1:0] cnt;

    // Wrap-around counter; runs regardless of scanner state.
    always_ff @(posedge i_clk) begin
      if (i_rst) cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else cnt <= cnt + 1'b1;
    end

    assign o_tick = (cnt == LAST);
  end else begin : g_off
    logic unused_ok;
    assign unused_ok = i_clk ^ i_rst;
    assign o_tick = 1'b0;
  end

endmodule

// File: rtl/nes_pad_scanner.sv
// nes_pad_scanner: shared latch/clock scanner for 1..4 NES/SNES pads.
// Define NES_PAD_DEBOUNCE_EN to require two equal scans per update.
module nes_pad_scanner
  import nes_pad_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 8,
  parameter int HALF_CYC = 162,
  parameter int POLL_CYC = 450000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_poll_req,
  input  logic [NUM_PADS-1:0]          i_serial_data,
  output logic                         o_data_latch,
  output logic                         o_data_clock,
  output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
  output logic                         o_valid,
  output logic                         o_busy
);

  localparam int CW = $clog2(2 * HALF_CYC);
  localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST_LATCH = CW'(2 * HALF_CYC - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF_CYC - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(NUM_BITS - 1);

  state_t state, state_n;
  logic [CW-1:0] phase;
  logic [IW-1:0] idx;
  logic [NUM_PADS-1:0] sync1, sync2;
  logic [NUM_PADS-1:0][NUM_BITS-1:0] btn;
  logic tick, start, last, capture, done;

  nes_pad_tick #(
    .POLL_CYC(POLL_CYC)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  assign start = i_poll_req | tick;
  assign capture = (state == ST_LOW) && last;
  assign done = (state == ST_DONE);
  assign o_busy = (state != ST_IDLE);
  assign o_buttons = btn;

  // Two-flop synchroniser; reset to the released (high) level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_serial_data;
      sync2 <= sync1;
    end
  end

  // Next state and end-of-phase detection.
  always_comb begin
    state_n = state;
    last = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_n = ST_LATCH;
      end
      ST_LATCH: begin
        last = (phase == LAST_LATCH);
        if (last) state_n = ST_LOW;
      end
      ST_LOW: begin
        last = (phase == LAST_HALF);
        if (last) state_n = (idx == LAST_BIT) ? ST_DONE : ST_HIGH;
      end
      ST_HIGH: begin
        last = (phase == LAST_HALF);
        if (last) state_n = ST_LOW;
      end
      ST_DONE: begin
        last = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, phase counter, bit index and registered pad lines.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      phase <= '0;
      idx <= '0;
      o_data_latch <= 1'b0;
      o_data_clock <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      state <= state_n;
      phase <= (state == ST_IDLE || last) ? '0 : phase + 1'b1;
      if (state == ST_LATCH) idx <= '0;
      else if (state == ST_HIGH && last) idx <= idx + 1'b1;
      o_data_latch <= (state_n == ST_LATCH);
      o_data_clock <= (state_n == ST_HIGH);
      o_valid <= done;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [NUM_BITS-1:0] sh;
    logic [NUM_BITS-1:0] bt;

    // Shadow capture at the end of each low half period.
    always_ff @(posedge i_clk) begin
      if (i_rst) sh <= '0;
      else if (capture) sh[idx] <= ~sync2[p];
    end

`ifdef NES_PAD_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prev;

    // Publish only when two consecutive scans agree.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        prev <= '0;
        bt <= '0;
      end else if (done) begin
        prev <= sh;
        if (sh == prev) bt <= sh;
      end
    end
`else
    // Publish every completed scan.
    always_ff @(posedge i_clk) begin
      if (i_rst) bt <= '0;
      else if (done) bt <= sh;
    end
`endif

    assign btn[p] = bt;
  end

endmodule

// File: tb/tb_nes_pad_scanner.sv
// tb_nes_pad_scanner: directed bench with behavioural pad models
// and a cycle-level timing model of the default scanner.
`timescale 1ns/1ps
module tb_nes_pad_scanner;

  localparam int H0 = 162;
  localparam int L0 = 2 * H0 + 8 * H0 + 7 * H0 + 1;
  localparam int H1 = 4;
  localparam int L1 = 2 * H1 + 16 * H1 + 15 * H1 + 1;
  localparam int H2 = 3;
  localparam int P2 = 5000;
`ifdef NES_PAD_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- DUT 0: defaults ----------------
  logic rst0 = 1'b1, poll0 = 1'b0;
  logic [1:0] sd0;
  logic lat0, dck0, val0, bsy0;
  logic [15:0] btn0;

  nes_pad_scanner #(
    .NUM_PADS(2), .NUM_BITS(8), .HALF_CYC(H0), .POLL_CYC(450000)
  ) u0 (
    .i_clk(clk), .i_rst(rst0), .i_poll_req(poll0),
    .i_serial_data(sd0), .o_data_latch(lat0), .o_data_clock(dck0),
    .o_buttons(btn0), .o_valid(val0), .o_busy(bsy0)
  );

  // ---------------- DUT 1: SNES, no auto-poll ----------------
  logic rstb = 1'b1, poll1 = 1'b0;
  logic [0:0] sd1;
  logic lat1, dck1, val1, bsy1;
  logic [15:0] btn1;

  nes_pad_scanner #(
    .NUM_PADS(1), .NUM_BITS(16), .HALF_CYC(H1), .POLL_CYC(0)
  ) u1 (
    .i_clk(clk), .i_rst(rstb), .i_poll_req(poll1),
    .i_serial_data(sd1), .o_data_latch(lat1), .o_data_clock(dck1),
    .o_buttons(btn1), .o_valid(val1), .o_busy(bsy1)
  );

  // ---------------- DUT 2: auto-poll only ----------------
  logic poll2 = 1'b0;
  logic [1:0] sd2;
  logic lat2, dck2, val2, bsy2;
  logic [15:0] btn2;

  nes_pad_scanner #(
    .NUM_PADS(2), .NUM_BITS(8), .HALF_CYC(H2), .POLL_CYC(P2)
  ) u2 (
    .i_clk(clk), .i_rst(rstb), .i_poll_req(poll2),
    .i_serial_data(sd2), .o_data_latch(lat2), .o_data_clock(dck2),
    .o_buttons(btn2), .o_valid(val2), .o_busy(bsy2)
  );

  // ---------------- controller models (4021-style) ----------------
  logic [7:0] pa0 = 8'hFF, pb0 = 8'hFF, sa0 = 8'hFF, sb0 = 8'hFF;
  logic pk0 = 1'b0;
  always @(posedge clk) begin
    pk0 <= dck0;
    if (lat0) begin
      sa0 <= pa0;
      sb0 <= pb0;
    end else if (dck0 && !pk0) begin
      sa0 <= {1'b1, sa0[7:1]};
      sb0 <= {1'b1, sb0[7:1]};
    end
  end
  assign sd0 = {sb0[0], sa0[0]};

  logic [15:0] pa1 = 16'hFFFF, sa1 = 16'hFFFF;
  logic pk1 = 1'b0;
  always @(posedge clk) begin
    pk1 <= dck1;
    if (lat1) sa1 <= pa1;
    else if (dck1 && !pk1) sa1 <= {1'b1, sa1[15:1]};
  end
  assign sd1 = sa1[0];

  logic [7:0] pa2 = 8'hFE, pb2 = 8'hEF, sa2 = 8'hFF, sb2 = 8'hFF;
  logic pk2 = 1'b0;
  always @(posedge clk) begin
    pk2 <= dck2;
    if (lat2) begin
      sa2 <= pa2;
      sb2 <= pb2;
    end else if (dck2 && !pk2) begin
      sa2 <= {1'b1, sa2[7:1]};
      sb2 <= {1'b1, sb2[7:1]};
    end
  end
  assign sd2 = {sb2[0], sa2[0]};

  // ---------------- event monitors ----------------
  int nl0 = 0, nc0 = 0, nv0 = 0, tr0 = 0, tv0 = 0;
  logic ql0 = 1'b0, qc0 = 1'b0;
  always @(negedge clk) begin
    ql0 <= lat0;
    qc0 <= dck0;
    if (lat0) nl0 <= nl0 + 1;
    if (lat0 && !ql0) tr0 <= cyc;
    if (dck0 && !qc0) nc0 <= nc0 + 1;
    if (val0) begin
      nv0 <= nv0 + 1;
      tv0 <= cyc;
    end
  end

  int nc1 = 0, nv1 = 0, nb1 = 0, tr1 = 0, tv1 = 0;
  logic ql1 = 1'b0, qc1 = 1'b0;
  always @(negedge clk) begin
    ql1 <= lat1;
    qc1 <= dck1;
    if (bsy1) nb1 <= nb1 + 1;
    if (lat1 && !ql1) tr1 <= cyc;
    if (dck1 && !qc1) nc1 <= nc1 + 1;
    if (val1) begin
      nv1 <= nv1 + 1;
      tv1 <= cyc;
    end
  end

  int r2 [4];
  int nr2 = 0, nv2 = 0, tv2 = 0;
  logic ql2 = 1'b0;
  always @(negedge clk) begin
    ql2 <= lat2;
    if (lat2 && !ql2 && nr2 < 4) begin
      r2[nr2] <= cyc;
      nr2 <= nr2 + 1;
    end
    if (val2) begin
      nv2 <= nv2 + 1;
      tv2 <= cyc;
    end
  end

  // ---------------- scan model for DUT 0 ----------------
  // A scan is a window of L0 cycles after an accepted request;
  // offset k inside it fixes the line levels, and the result
  // appears the cycle after the window closes.
  logic m_act = 1'b0, m_val = 1'b0;
  int m_k = 0;
  logic [15:0] m_btn = '0, m_prev = '0;

  function automatic logic [15:0] publish(input logic [15:0] nw,
                                          input logic [15:0] prev,
                                          input logic [15:0] cur);
    logic [15:0] r;
    r = cur;
    for (int p = 0; p < 2; p++)
      if (!DEB || nw[p*8+:8] == prev[p*8+:8]) r[p*8+:8] = nw[p*8+:8];
    return r;
  endfunction

  function automatic logic [19:0] expect0(input logic act, input int k,
                                          input logic v,
                                          input logic [15:0] b);
    logic el, ec;
    el = act && (k < 2 * H0);
    ec = act && (k >= 2 * H0) && (k < L0 - 1) &&
         (((k - 2 * H0) / H0) % 2 == 1);
    return {el, ec, act, v, b};
  endfunction

  always @(posedge clk) begin
    if (rst0) begin
      m_act <= 1'b0;
      m_k <= 0;
      m_val <= 1'b0;
      m_btn <= '0;
      m_prev <= '0;
    end else begin
      m_val <= 1'b0;
      if (!m_act) begin
        if (poll0) begin
          m_act <= 1'b1;
          m_k <= 0;
        end
      end else if (m_k == L0 - 1) begin
        m_act <= 1'b0;
        m_val <= 1'b1;
        m_btn <= publish(~{pb0, pa0}, m_prev, m_btn);
        m_prev <= ~{pb0, pa0};
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk)
    chk("u0 cycle model", {lat0, dck0, bsy0, val0, btn0},
        expect0(m_act, m_k, m_val, m_btn));

  task automatic pulse0();
    poll0 = 1'b1;
    step(1);
    poll0 = 1'b0;
  endtask

  task automatic pulse1();
    poll1 = 1'b1;
    step(1);
    poll1 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bl, bc, bv, t_rel;
    step(4);
    rst0 = 1'b0;
    rstb = 1'b0;
    t_rel = cyc;
    chk("u0 reset outputs", {lat0, dck0, val0, bsy0, btn0}, 0);
    chk("u1 reset outputs", {lat1, dck1, val1, bsy1, btn1}, 0);

    // SNES instance: nothing without a request, then bit 11 only.
    step(2000);
    chk("u1 no auto scan busy", nb1, 0);
    chk("u1 no auto scan valid", nv1, 0);
    pa1 = 16'hF7FF;
    bc = nc1;
    pulse1();
    step(L1 + 5);
    chk("u1 s1 clock pulses", nc1 - bc, 15);
    chk("u1 s1 latency", tv1 - tr1, 133);
    chk("u1 s1 buttons", btn1, DEB ? 16'h0000 : 16'h0800);
    bc = nc1;
    pulse1();
    step(L1 + 5);
    chk("u1 s2 clock pulses", nc1 - bc, 15);
    chk("u1 s2 buttons", btn1, 16'h0800);
    chk("u1 valid count", nv1, 2);

    // Default instance, scan 1: A+Start on pad 0.
    pa0 = 8'hF6;
    pb0 = 8'hFF;
    bl = nl0; bc = nc0; bv = nv0;
    pulse0();
    step(L0 + 5);
    chk("u0 s1 latch cycles", nl0 - bl, 324);
    chk("u0 s1 clock pulses", nc0 - bc, 7);
    chk("u0 s1 valid count", nv0 - bv, 1);
    chk("u0 s1 latency", tv0 - tr0, 2755);
    chk("u0 s1 buttons", btn0, DEB ? 16'h0000 : 16'h0009);

    // Scan 2 with a second request 100 cycles in.
    pa0 = 8'h00;
    pb0 = 8'h7F;
    bl = nl0; bv = nv0;
    pulse0();
    step(100);
    pulse0();
    step(L0 + 10);
    chk("u0 s2 latch cycles", nl0 - bl, 324);
    chk("u0 s2 single valid", nv0 - bv, 1);
    chk("u0 s2 latency", tv0 - tr0, 2755);
    chk("u0 s2 buttons", btn0, DEB ? 16'h0000 : 16'h80FF);

    // Scan 3 repeats scan 2.
    bv = nv0;
    pulse0();
    step(L0 + 5);
    chk("u0 s3 valid count", nv0 - bv, 1);
    chk("u0 s3 buttons", btn0, 16'h80FF);

    // Reset during the high half of bit 3.
    pa0 = 8'hF6;
    pb0 = 8'hFF;
    pulse0();
    step(9 * H0 + 50);
    chk("u0 clock high pre-reset", {dck0, bsy0}, 2'b11);
    bv = nv0;
    rst0 = 1'b1;
    step(1);
    chk("u0 abort lines", {lat0, dck0, bsy0, val0, btn0}, 0);
    step(2);
    rst0 = 1'b0;
    step(L0);
    chk("u0 abort no valid", nv0 - bv, 0);
    chk("u0 abort buttons", btn0, 0);

    // Auto-poll instance ran alongside everything above.
    while (cyc < t_rel + 3 * P2 + 100) step(1);
    chk("u2 first poll", r2[0] - t_rel, 5000);
    chk("u2 period a", r2[1] - r2[0], 5000);
    chk("u2 period b", r2[2] - r2[1], 5000);
    chk("u2 scan count", nr2, 3);
    chk("u2 valid count", nv2, 3);
    chk("u2 latency", tv2 - r2[2], 52);
    chk("u2 buttons", btn2, 16'h1001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
